// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: E-stage HI/LO owner. Single-cycle MULT/MULTU, MTHI/MTLO,
// combinational MFHI/MFLO read, and a 32-step restoring divider (DIV/DIVU)
// that stalls the pipeline while it iterates.
// Optional build macro HILO_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulation
// into {HI,LO}; without it those codes leave HI/LO untouched.
module hilo_muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int DIV_ITER = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       aluopE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             stallE,
    input  logic             flushE,
    output logic             div_stallE,
    output logic [WIDTH-1:0] hilo_resultE,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    // Local copy of the ALUOP codes this unit decodes; keep in step with defines.vh.
    localparam logic [7:0] ALUOP_MFHI  = 8'h10;
    localparam logic [7:0] ALUOP_MTHI  = 8'h11;
    localparam logic [7:0] ALUOP_MFLO  = 8'h12;
    localparam logic [7:0] ALUOP_MTLO  = 8'h13;
    localparam logic [7:0] ALUOP_MULT  = 8'h18;
    localparam logic [7:0] ALUOP_MULTU = 8'h19;
    localparam logic [7:0] ALUOP_DIV   = 8'h1A;
    localparam logic [7:0] ALUOP_DIVU  = 8'h1B;
`ifdef HILO_MADD_EN
    localparam logic [7:0] ALUOP_MADD  = 8'h1C;
    localparam logic [7:0] ALUOP_MADDU = 8'h1D;
    localparam logic [7:0] ALUOP_MSUB  = 8'h1E;
    localparam logic [7:0] ALUOP_MSUBU = 8'h1F;
`endif

    localparam int CNT_W = $clog2(DIV_ITER);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0]   quo_q, quo_d;     // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;   // divisor magnitude
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;

    logic [2*WIDTH-1:0] sprod_s;
    logic [2*WIDTH-1:0] uprod_s;
    logic [WIDTH:0]     shift_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH-1:0]   q_fix_s;
    logic [WIDTH-1:0]   r_fix_s;
    logic               is_sdiv_s;
    logic               commit_s;
    logic               div_stall_s;

    // Next-state, datapath and HI/LO write selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        div_stall_s = 1'b0;

        commit_s  = ~stallE & ~flushE;
        sprod_s   = $signed({{WIDTH{srcaE[WIDTH-1]}}, srcaE}) *
                    $signed({{WIDTH{srcbE[WIDTH-1]}}, srcbE});
        uprod_s   = {{WIDTH{1'b0}}, srcaE} * {{WIDTH{1'b0}}, srcbE};
        is_sdiv_s = (aluopE == ALUOP_DIV);
        a_mag_s   = (is_sdiv_s && srcaE[WIDTH-1]) ? (~srcaE + {{(WIDTH-1){1'b0}}, 1'b1}) : srcaE;
        b_mag_s   = (is_sdiv_s && srcbE[WIDTH-1]) ? (~srcbE + {{(WIDTH-1){1'b0}}, 1'b1}) : srcbE;
        shift_s   = {rem_q, quo_q[WIDTH-1]};
        diff_s    = shift_s - {1'b0, dvsr_q};
        q_fix_s   = qneg_q ? (~quo_q + {{(WIDTH-1){1'b0}}, 1'b1}) : quo_q;
        r_fix_s   = rneg_q ? (~rem_q + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_q;

        case (state_q)
            S_IDLE: begin
                if (flushE) begin
                    state_d = S_IDLE;
                end else if (aluopE == ALUOP_DIV || aluopE == ALUOP_DIVU) begin
                    state_d     = S_BUSY;
                    div_stall_s = 1'b1;
                    cnt_d       = {CNT_W{1'b0}};
                    rem_d       = {WIDTH{1'b0}};
                    quo_d       = a_mag_s;
                    dvsr_d      = b_mag_s;
                    qneg_d      = is_sdiv_s & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                    rneg_d      = is_sdiv_s & srcaE[WIDTH-1];
                end else if (commit_s) begin
                    case (aluopE)
                        ALUOP_MULT:  {hi_d, lo_d} = sprod_s;
                        ALUOP_MULTU: {hi_d, lo_d} = uprod_s;
                        ALUOP_MTHI:  hi_d = srcaE;
                        ALUOP_MTLO:  lo_d = srcaE;
`ifdef HILO_MADD_EN
                        ALUOP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + sprod_s;
                        ALUOP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + uprod_s;
                        ALUOP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - sprod_s;
                        ALUOP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - uprod_s;
`endif
                        default: begin
                            hi_d = hi_q;
                            lo_d = lo_q;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (flushE) begin
                    state_d = S_IDLE;
                end else begin
                    div_stall_s = 1'b1;
                    // Restoring step: keep the trial difference only if it did not borrow.
                    if (!diff_s[WIDTH]) begin
                        rem_d = diff_s[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shift_s[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_DONE: begin
                if (flushE) begin
                    state_d = S_IDLE;
                end else if (!stallE) begin
                    state_d = S_IDLE;
                    // Zero divisor: after the full run the remainder holds the dividend
                    // magnitude; restoring its sign returns the dividend as it was latched.
                    if (dvsr_q == {WIDTH{1'b0}}) begin
                        lo_d = {WIDTH{1'b1}};
                        hi_d = r_fix_s;
                    end else begin
                        lo_d = q_fix_s;
                        hi_d = r_fix_s;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Combinational outputs: stall request (dropped under reset) and MFHI/MFLO read.
    always_comb begin
        div_stallE   = div_stall_s & rst;
        hilo_resultE = {WIDTH{1'b0}};
        case (aluopE)
            ALUOP_MFHI: hilo_resultE = hi_q;
            ALUOP_MFLO: hilo_resultE = lo_q;
            default:    hilo_resultE = {WIDTH{1'b0}};
        endcase
    end

    // State and HI/LO registers, cleared asynchronously by active-low rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            dvsr_q  <= {WIDTH{1'b0}};
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execute-stage unit that consumes the registered `aluopE` code and the E-stage operands.
- Owns the architectural HI/LO registers and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO; returns HI or LO for MFHI/MFLO.
- Multiply: single cycle. Divide: 32-iteration restoring state machine that stalls the pipeline until done.
- Its result is muxed with the main ALU result in E.

Parameters:
- WIDTH, 32, operand and HI/LO width (only 32 is supported).
- DIV_ITER, 32, divider iteration count (must equal WIDTH).

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous reset, active-low (asserted when 0).
- aluopE  input  8  E-stage ALU operation code (`ALUOP_*` from defines.vh).
- srcaE  input  32  operand A (rs); dividend / multiplicand / MTHI-MTLO data.
- srcbE  input  32  operand B (rt); divisor / multiplier.
- stallE  input  1  E stage held by another stall source.
- flushE  input  1  E-stage instruction squashed.
- div_stallE  output  1  divider busy; hazard unit freezes F/D/E.
- hilo_resultE  output  32  HI for `ALUOP_MFHI`, LO for `ALUOP_MFLO`, else 0.
- hi_o  output  32  current HI register.
- lo_o  output  32  current LO register.

Behaviour:
- Reset (rst=0, async): HI=0, LO=0, state=IDLE, counter=0, div_stallE=0.
- "Commit edge" means a rising edge with stallE=0 and flushE=0.
- MULT (signed) / MULTU (unsigned): 64-bit product; {HI,LO} written at the commit edge. Zero added latency.
- MTHI / MTLO: HI or LO ← srcaE at the commit edge.
- MFHI / MFLO: combinational read of the current register, no bypass needed. A write at the commit edge is visible to the next instruction in E.
- Divider FSM states: IDLE, BUSY, DONE.
- IDLE → BUSY:
  - Condition: aluopE is DIV/DIVU and flushE=0.
  - Latch |srcaE| and |srcbE| (signed) or the raw values (unsigned).
  - Latch quotient sign = sa^sb and remainder sign = sa (signed only).
  - counter ← 0. div_stallE=1 during this cycle (combinational).
- BUSY:
  - One restoring step per cycle: shift the remainder:quotient pair, trial-subtract the divisor, set the quotient bit.
  - div_stallE=1.
  - When counter reaches DIV_ITER-1 → DONE.
- DONE:
  - div_stallE=0.
  - Apply sign correction: negate quotient if its sign bit is set; negate remainder if the dividend was negative.
  - If stallE=0: LO ← quotient, HI ← remainder, → IDLE.
  - If stallE=1: stay in DONE, no write.
- Divide latency: 1 start cycle + 32 BUSY cycles with stall high, then 1 DONE cycle (34 cycles in E).
- Divide by zero:
  - Full latency still taken, no sign correction.
  - LO=32'hFFFFFFFF, HI=srcaE as latched at start.
- Signed 0x80000000 / -1: LO=0x80000000, HI=0 (natural result of magnitude arithmetic).
- flushE=1 in any state:
  - Next state IDLE; no HI/LO write.
  - div_stallE forced 0 combinationally while flushE=1.
- Unlisted aluop codes: no state change.

Optional Feature:
- Macro: HILO_MADD_EN.
- Defined: adds `ALUOP_MADD`, `ALUOP_MADDU`, `ALUOP_MSUB`, `ALUOP_MSUBU`.
  - {HI,LO} ← {HI,LO} ± (srcaE*srcbE), signed or unsigned per opcode, 64-bit wrap-around.
  - Written at the commit edge; single cycle.
- Undefined: these codes fall under the unlisted-aluop rule (no HI/LO change); no accumulator adder is synthesised.

Test Plan:
- MULT 0xFFFFFFFE×3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands → HI=0x00000002, LO=0xFFFFFFFA. Then MFHI → hilo_resultE=0x00000002.
- DIVU 100/7 → div_stallE high exactly 33 cycles, then LO=14, HI=2. DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 5/0 → LO=0xFFFFFFFF, HI=5, 34-cycle occupancy. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Start DIV 100/7 with HI=LO=0x1234; assert flushE at BUSY cycle 10 → div_stallE drops the same cycle, state IDLE, HI/LO stay 0x1234.
- DIV completes with stallE=1 held 3 cycles in DONE → no write until stallE=0, single write, no restart. MTHI 0xA5A5A5A5 followed by MFHI → 0xA5A5A5A5.
- rst pulsed low mid-BUSY → HI=LO=0, div_stallE=0 immediately (async). HILO_MADD_EN: HI:LO=0:5, MADD 2×3 → LO=11; MSUBU 1×12 → HI=LO=0xFFFFFFFF.
